// File: rtl/sig_dump_monitor.sv
// Signature-window monitor on the data-memory request port: decodes stop,
// trap and per-channel dump writes, queues dump records in a first-word
// fall-through FIFO and sequences run -> drain -> done.
// Window map: +0x00 stop, +0x08 trap, +0x10 + 8*c dump channel c.
module sig_dump_monitor #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter logic [63:0] SIG_BASE     = 64'h0,
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned DRAIN_CYCLES = 50,
  parameter int unsigned IDX_W        = 16,
  parameter int unsigned CNT_W        = 32,
  localparam int unsigned STRB_W      = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [STRB_W-1:0] mem_strb_i,
  input  logic [DATA_W-1:0] mem_wdata_t0_i,
  input  logic [CNT_W-1:0]  simlen_i,
  input  logic              stop_on_trap_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [2:0]        dump_ch_o,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [DATA_W-1:0] dump_taint_o,
  output logic              done_o,
  output logic [1:0]        done_cause_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [7:0]        trap_cnt_o,
  output logic [7:0]        drop_cnt_o,
  output logic              strb_err_o
);

  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W      = AW + 1;
  localparam int unsigned DRN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic [1:0]         cause_q, cause_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [7:0]         trap_q, trap_d;
  logic [7:0]         drop_q, drop_d;
  logic               strb_err_q, strb_err_d;
  logic [IDX_W-1:0]   idx_q [NUM_CH];
  logic [IDX_W-1:0]   idx_d [NUM_CH];

  logic [2:0]         mem_ch_q    [FIFO_DEPTH];
  logic [IDX_W-1:0]   mem_idx_q   [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_data_q  [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_taint_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;

  logic [ADDR_W-1:0]  off;
  logic               wr_c, stop_hit, trap_hit, ch_hit, simlen_hit;
  logic [2:0]         rec_ch;
  logic [IDX_W-1:0]   rec_idx;
  logic               push, pop, full, empty;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = dump_valid_o & dump_ready_i;

  assign dump_valid_o = !empty;
  assign dump_ch_o    = mem_ch_q[rd_ptr_q[AW-1:0]];
  assign dump_idx_o   = mem_idx_q[rd_ptr_q[AW-1:0]];
  assign dump_data_o  = mem_data_q[rd_ptr_q[AW-1:0]];
  assign dump_taint_o = mem_taint_q[rd_ptr_q[AW-1:0]];

  assign done_o       = done_q;
  assign done_cause_o = cause_q;
  assign cycle_cnt_o  = cyc_q;
  assign trap_cnt_o   = trap_q;
  assign drop_cnt_o   = drop_q;
  assign strb_err_o   = strb_err_q;

  // Address decode, run/drain/done sequencing, counters and record capture.
  always_comb begin
    state_d    = state_q;
    drn_d      = drn_q;
    cause_d    = cause_q;
    cyc_d      = cyc_q;
    trap_d     = trap_q;
    drop_d     = drop_q;
    strb_err_d = strb_err_q;
    idx_d      = idx_q;
    push       = 1'b0;
    ch_hit     = 1'b0;
    rec_ch     = 3'd0;
    rec_idx    = '0;

    off        = mem_addr_i - ADDR_W'(SIG_BASE);
    wr_c       = mem_req_i & mem_we_i;
    stop_hit   = wr_c && (off == ADDR_W'(0));
    trap_hit   = wr_c && (off == ADDR_W'(8));
    simlen_hit = (simlen_i != '0) && (cyc_q == simlen_i - CNT_W'(1));

    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (wr_c && (off == ADDR_W'(16 + 8 * c))) begin
        ch_hit  = 1'b1;
        rec_ch  = 3'(c);
        rec_idx = idx_q[c];
        if (state_q == ST_RUN) idx_d[c] = idx_q[c] + IDX_W'(1);
      end
    end

    case (state_q)
      ST_RUN: begin
        if (simlen_hit) begin
          state_d = ST_DONE;
          cause_d = 2'd3;
        end else if (stop_hit || (trap_hit && stop_on_trap_i)) begin
          cause_d = stop_hit ? 2'd1 : 2'd2;
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
            drn_d   = DRN_W'(DRAIN_LOAD);
          end
        end
      end
      ST_DRAIN: begin
        if (simlen_hit || (drn_q == '0)) state_d = ST_DONE;
        else                             drn_d   = drn_q - DRN_W'(1);
      end
      default: ;
    endcase

    // The count freezes on the value held when the sequence finishes.
    if ((state_q != ST_DONE) && (state_d != ST_DONE)) cyc_d = cyc_q + CNT_W'(1);

    if (trap_hit && (trap_q != 8'hFF)) trap_d = trap_q + 8'd1;

    // Full is judged on the registered state; a same-cycle pop does not make room.
    if ((state_q == ST_RUN) && ch_hit) begin
      if (mem_strb_i != '1) strb_err_d = 1'b1;
      if (full) begin
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else begin
        push = 1'b1;
      end
    end

    done_d = (state_d == ST_DONE);
  end

  // State, counters and FIFO storage with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      drn_q      <= '0;
      cause_q    <= 2'd0;
      done_q     <= 1'b0;
      cyc_q      <= '0;
      trap_q     <= 8'd0;
      drop_q     <= 8'd0;
      strb_err_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) idx_q[c] <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_ch_q[i]    <= 3'd0;
        mem_idx_q[i]   <= '0;
        mem_data_q[i]  <= '0;
        mem_taint_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      drn_q      <= drn_d;
      cause_q    <= cause_d;
      done_q     <= done_d;
      cyc_q      <= cyc_d;
      trap_q     <= trap_d;
      drop_q     <= drop_d;
      strb_err_q <= strb_err_d;
      idx_q      <= idx_d;
      if (push) begin
        mem_ch_q[wr_ptr_q[AW-1:0]]    <= rec_ch;
        mem_idx_q[wr_ptr_q[AW-1:0]]   <= rec_idx;
        mem_data_q[wr_ptr_q[AW-1:0]]  <= mem_wdata_i;
        mem_taint_q[wr_ptr_q[AW-1:0]] <= mem_wdata_t0_i;
        wr_ptr_q                      <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

endmodule

// File: tb/tb_sig_dump_monitor.sv
// Scoreboard bench for sig_dump_monitor: expected dump records are queued
// at stimulus time and checked by a monitor whenever the drain port pops.
module tb_sig_dump_monitor;

  localparam logic [63:0] A_STOP = 64'h00;
  localparam logic [63:0] A_TRAP = 64'h08;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_req_i, mem_we_i;
  logic [63:0] mem_addr_i, mem_wdata_i, mem_wdata_t0_i;
  logic [7:0]  mem_strb_i;
  logic [31:0] simlen_i;
  logic        stop_on_trap_i;
  logic        dump_valid_o, dump_ready_i;
  logic [2:0]  dump_ch_o;
  logic [15:0] dump_idx_o;
  logic [63:0] dump_data_o, dump_taint_o;
  logic        done_o;
  logic [1:0]  done_cause_o;
  logic [31:0] cycle_cnt_o;
  logic [7:0]  trap_cnt_o, drop_cnt_o;
  logic        strb_err_o;

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] idx;
    logic [63:0] data;
    logic [63:0] taint;
    bit          chk_t;
    int          t;
  } rec_t;

  rec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   tb_cyc = 0;

  sig_dump_monitor dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_strb_i     (mem_strb_i),
    .mem_wdata_t0_i (mem_wdata_t0_i),
    .simlen_i       (simlen_i),
    .stop_on_trap_i (stop_on_trap_i),
    .dump_valid_o   (dump_valid_o),
    .dump_ready_i   (dump_ready_i),
    .dump_ch_o      (dump_ch_o),
    .dump_idx_o     (dump_idx_o),
    .dump_data_o    (dump_data_o),
    .dump_taint_o   (dump_taint_o),
    .done_o         (done_o),
    .done_cause_o   (done_cause_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .trap_cnt_o     (trap_cnt_o),
    .drop_cnt_o     (drop_cnt_o),
    .strb_err_o     (strb_err_o)
  );

  always #5 clk = ~clk;

  // Reference cycle number: 0 in the first cycle after reset release.
  always @(posedge clk) tb_cyc <= rst_i ? 0 : tb_cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, tb_cyc);
    end
  endtask

  // Drain-port monitor: every pop must match the oldest expected record.
  always @(negedge clk) begin
    if (!rst_i && dump_valid_o && dump_ready_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rec_unexpected: got ch%0d idx%0d data 0x%0h, nothing expected (cycle %0d)",
                 dump_ch_o, dump_idx_o, dump_data_o, tb_cyc);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        if (dump_ch_o !== e.ch || dump_idx_o !== e.idx ||
            dump_data_o !== e.data || dump_taint_o !== e.taint) begin
          n_err++;
          $display("FAIL rec: got ch%0d idx%0d d=0x%0h t=0x%0h expected ch%0d idx%0d d=0x%0h t=0x%0h",
                   dump_ch_o, dump_idx_o, dump_data_o, dump_taint_o, e.ch, e.idx, e.data, e.taint);
        end
        if (e.chk_t) begin
          n_vec++;
          if (tb_cyc != e.t) begin
            n_err++;
            $display("FAIL rec_time: got cycle %0d expected cycle %0d", tb_cyc, e.t);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic step_to(input int n);
    int guard = 0;
    while (tb_cyc < n && guard < 5000) begin step(1); guard++; end
    chk("step_to", 64'(tb_cyc), 64'(n));
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                    input logic we);
    mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr;
    mem_wdata_i = data; mem_wdata_t0_i = 64'hF0; mem_strb_i = strb;
    step(1);
    mem_req_i = 1'b0; mem_we_i = 1'b0;
  endtask

  // Dump write on channel ch; queue the expected record when it should be captured.
  task automatic dump(input int ch, input logic [63:0] data, input logic [15:0] idx,
                      input bit expect_rec, input bit chk_t, input logic [7:0] strb);
    rec_t e;
    if (expect_rec) begin
      e.ch = 3'(ch); e.idx = idx; e.data = data; e.taint = 64'hF0;
      e.chk_t = chk_t; e.t = tb_cyc + 1;
      exp_q.push_back(e);
    end
    wr(64'(16 + 8 * ch), data, strb, 1'b1);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin step(1); guard++; end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_i = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0;
    mem_wdata_i = '0; mem_wdata_t0_i = '0; mem_strb_i = 8'hFF;
    simlen_i = '0; stop_on_trap_i = 1'b0; dump_ready_i = 1'b1;

    // Reset state and in-order records, one cycle after each write.
    do_reset();
    chk("rst_valid", 64'(dump_valid_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_cyc", 64'(cycle_cnt_o), 64'd0);
    dump(0, 64'h1111, 16'd0, 1'b1, 1'b1, 8'hFF);
    dump(1, 64'h2222, 16'd0, 1'b1, 1'b1, 8'hFF);
    dump(2, 64'h3333, 16'd0, 1'b1, 1'b1, 8'hFF);
    dump(0, 64'h4444, 16'd1, 1'b1, 1'b1, 8'hFF);
    wait_drain();
    chk("strb_clean", 64'(strb_err_o), 64'd0);

    // Stop at cycle 100: done at 151 with cause 1; dumps in drain and reads ignored.
    do_reset();
    step_to(50);
    wr(A_STOP, 64'h1, 8'hFF, 1'b0);
    step_to(100);
    chk("cyc_100", 64'(cycle_cnt_o), 64'd100);
    wr(A_STOP, 64'h1, 8'hFF, 1'b1);
    step_to(120);
    dump(0, 64'hDEAD, 16'd0, 1'b0, 1'b0, 8'hFF);
    step_to(150);
    chk("stop_done_150", 64'(done_o), 64'd0);
    step(1);
    chk("stop_done_151", 64'(done_o), 64'd1);
    chk("stop_cause", 64'(done_cause_o), 64'd1);
    chk("stop_cyc", 64'(cycle_cnt_o), 64'd150);
    step(5);
    chk("stop_cyc_frozen", 64'(cycle_cnt_o), 64'd150);

    // Trap without then with stop_on_trap.
    do_reset();
    step(3);
    wr(A_TRAP, 64'h1, 8'hFF, 1'b1);
    chk("trap_cnt1", 64'(trap_cnt_o), 64'd1);
    chk("trap_run", 64'(done_o), 64'd0);
    dump(1, 64'hAB, 16'd0, 1'b1, 1'b0, 8'hFF);
    stop_on_trap_i = 1'b1;
    t = tb_cyc;
    wr(A_TRAP, 64'h1, 8'hFF, 1'b1);
    chk("trap_cnt2", 64'(trap_cnt_o), 64'd2);
    step_to(t + 50);
    chk("trap_done_early", 64'(done_o), 64'd0);
    step(1);
    chk("trap_done", 64'(done_o), 64'd1);
    chk("trap_cause", 64'(done_cause_o), 64'd2);
    wr(A_TRAP, 64'h1, 8'hFF, 1'b1);
    chk("trap_cnt_done", 64'(trap_cnt_o), 64'd3);
    stop_on_trap_i = 1'b0;

    // Simlen expiry, alone and against a same-cycle stop.
    simlen_i = 32'd200;
    do_reset();
    step_to(199);
    chk("sim_done_199", 64'(done_o), 64'd0);
    step(1);
    chk("sim_done_200", 64'(done_o), 64'd1);
    chk("sim_cause", 64'(done_cause_o), 64'd3);
    chk("sim_cyc", 64'(cycle_cnt_o), 64'd199);
    step(10);
    chk("sim_cyc_frozen", 64'(cycle_cnt_o), 64'd199);
    do_reset();
    step_to(199);
    wr(A_STOP, 64'h1, 8'hFF, 1'b1);
    chk("sim_stop_done", 64'(done_o), 64'd1);
    chk("sim_stop_cause", 64'(done_cause_o), 64'd3);
    simlen_i = 32'd0;

    // Overflow with the consumer stalled: 8 queued, 2 dropped, index keeps advancing.
    dump_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++)
      dump(0, 64'(32'h100 + i), 16'(i), (i < 8), 1'b0, 8'hFF);
    chk("ovf_drop", 64'(drop_cnt_o), 64'd2);
    chk("ovf_valid", 64'(dump_valid_o), 64'd1);
    chk("ovf_head_idx", 64'(dump_idx_o), 64'd0);
    chk("ovf_head_data", dump_data_o, 64'h100);
    dump_ready_i = 1'b1;
    wait_drain();
    dump(0, 64'h777, 16'd10, 1'b1, 1'b0, 8'hFF);
    wait_drain();

    // Partial strobe, then reset with records queued.
    do_reset();
    dump(2, 64'h5555, 16'd0, 1'b1, 1'b0, 8'h0F);
    chk("strb_err", 64'(strb_err_o), 64'd1);
    wait_drain();
    dump_ready_i = 1'b0;
    wr(A_TRAP, 64'h1, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) dump(0, 64'(i), 16'(i), 1'b0, 1'b0, 8'hFF);
    chk("pre_rst_valid", 64'(dump_valid_o), 64'd1);
    chk("pre_rst_trap", 64'(trap_cnt_o), 64'd1);
    rst_i = 1'b1;
    step(1);
    chk("mid_rst_valid", 64'(dump_valid_o), 64'd0);
    chk("mid_rst_trap", 64'(trap_cnt_o), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt_o), 64'd0);
    chk("mid_rst_strb", 64'(strb_err_o), 64'd0);
    chk("mid_rst_cyc", 64'(cycle_cnt_o), 64'd0);
    chk("mid_rst_cause", 64'(done_cause_o), 64'd0);
    rst_i = 1'b0;
    dump_ready_i = 1'b1;
    dump(0, 64'h9999, 16'd0, 1'b1, 1'b0, 8'hFF);
    wait_drain();
    step(5);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
